// File: rtl/msrv32_fetch_redirect_pkg.sv
// Shared msrv32 definitions: control-transfer opcodes (opcode[6:2]) and fetch FSM encodings.
// Also used by the branch unit.
package msrv32_fetch_redirect_pkg;

    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    localparam logic [1:0] RESET_S = 2'd0;
    localparam logic [1:0] REQ_S   = 2'd1;
    localparam logic [1:0] WAIT_S  = 2'd2;
    localparam logic [1:0] HOLD_S  = 2'd3;

    function automatic logic is_xfer_op(input logic [4:0] op);
        return (op == OPC_JAL) || (op == OPC_JALR) || (op == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/msrv32_fetch_redirect_if.sv
// Instruction-memory fetch bus: request handshake plus in-order response.
interface msrv32_fetch_redirect_if;

    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in;
    logic        imem_rsp_valid_in;
    logic [31:0] imem_rsp_data_in;

    modport master (
        output imem_req_valid_out,
        output imem_req_addr_out,
        input  imem_req_ready_in,
        input  imem_rsp_valid_in,
        input  imem_rsp_data_in
    );

    modport slave (
        input  imem_req_valid_out,
        input  imem_req_addr_out,
        output imem_req_ready_in,
        output imem_rsp_valid_in,
        output imem_rsp_data_in
    );

endinterface

// File: rtl/msrv32_target_gen.sv
// Control-transfer target and misalignment check for the instruction in execute.
module msrv32_target_gen
    import msrv32_fetch_redirect_pkg::*;
(
    input  logic [4:0]  opcode_in,
    input  logic [31:0] exec_pc_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    output logic [31:0] target_out,
    output logic        misaligned_out
);

    logic [31:0] sum;

    always_comb begin
        if (opcode_in == OPC_JALR) begin
            sum        = rs1_in + imm_in;
            target_out = {sum[31:1], 1'b0};
        end else begin
            sum        = exec_pc_in + imm_in;
            target_out = sum;
        end
        misaligned_out = (target_out[1:0] != 2'b00);
    end

endmodule

// File: rtl/msrv32_fetch_redirect.sv
// Fetch sequencer with one outstanding imem request and branch/jump redirect handling.
module msrv32_fetch_redirect
    import msrv32_fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic                          ms_riscv32_mp_clk_in,
    input  logic                          ms_riscv32_mp_rst_n_in,
    input  logic                          branch_taken_in,
    input  logic                          exec_valid_in,
    input  logic [4:0]                    opcode_in,
    input  logic [31:0]                   exec_pc_in,
    input  logic [31:0]                   rs1_in,
    input  logic [31:0]                   imm_in,
    input  logic                          stall_in,
    msrv32_fetch_redirect_if.master       imem,
    output logic                          instr_valid_out,
    output logic [31:0]                   instr_out,
    output logic [31:0]                   instr_pc_out,
    output logic                          flush_out,
    output logic                          misaligned_exc_out,
    output logic [31:0]                   misaligned_addr_out
);

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        stale_q, stale_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        flush_q, exc_q;
    logic [31:0] exc_addr_q;

    logic        redirect;
    logic        misaligned;
    logic [31:0] target;
    logic [31:0] redirect_pc;

    msrv32_target_gen u_target_gen (
        .opcode_in      (opcode_in),
        .exec_pc_in     (exec_pc_in),
        .rs1_in         (rs1_in),
        .imm_in         (imm_in),
        .target_out     (target),
        .misaligned_out (misaligned)
    );

    assign redirect    = exec_valid_in && branch_taken_in && is_xfer_op(opcode_in);
    assign redirect_pc = misaligned ? TRAP_VEC : target;

    assign imem.imem_req_valid_out = (state_q == REQ_S);
    assign imem.imem_req_addr_out  = (state_q == REQ_S) ? fetch_pc_q : 32'h0;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        stale_d       = stale_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        unique case (state_q)
            RESET_S: begin
                state_d    = REQ_S;
                fetch_pc_d = redirect ? redirect_pc : RESET_PC;
            end
            REQ_S: begin
                if (imem.imem_req_ready_in) begin
                    // An accepted request cannot be withdrawn; a coincident redirect marks it stale.
                    state_d    = WAIT_S;
                    req_pc_d   = fetch_pc_q;
                    stale_d    = redirect;
                    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + 32'd4;
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
            end
            WAIT_S: begin
                if (redirect) fetch_pc_d = redirect_pc;
                if (imem.imem_rsp_valid_in) begin
                    stale_d = 1'b0;
                    if (stale_q || redirect) begin
                        state_d = REQ_S;
                    end else begin
                        state_d       = HOLD_S;
                        instr_valid_d = 1'b1;
                        instr_d       = imem.imem_rsp_data_in;
                        instr_pc_d    = req_pc_q;
                    end
                end else if (redirect) begin
                    // Keep waiting so only one request is ever outstanding.
                    stale_d = 1'b1;
                end
            end
            HOLD_S: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ_S;
                    fetch_pc_d    = redirect_pc;
                end else if (!stall_in) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ_S;
                end
            end
            default: state_d = RESET_S;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q       <= RESET_S;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= 32'h0;
            stale_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            flush_q       <= 1'b0;
            exc_q         <= 1'b0;
            exc_addr_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            stale_q       <= stale_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            flush_q       <= redirect;
            exc_q         <= redirect && misaligned;
            exc_addr_q    <= (redirect && misaligned) ? target : 32'h0;
        end
    end

    assign instr_valid_out     = instr_valid_q;
    assign instr_out           = instr_q;
    assign instr_pc_out        = instr_pc_q;
    assign flush_out           = flush_q;
    assign misaligned_exc_out  = exc_q;
    assign misaligned_addr_out = exc_addr_q;

endmodule

// File: tb/tb_msrv32_fetch_redirect.sv
// Directed and random checks of msrv32_fetch_redirect against a transaction-level model.
module tb_msrv32_fetch_redirect;
    import msrv32_fetch_redirect_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] TV  = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        branch_taken, exec_valid, stall;
    logic [4:0]  opcode;
    logic [31:0] exec_pc, rs1, imm;
    logic        instr_valid, flush, exc;
    logic [31:0] instr, instr_pc, exc_addr;

    msrv32_fetch_redirect_if imem ();

    always #5 clk = ~clk;

    msrv32_fetch_redirect #(
        .RESET_PC (RPC),
        .TRAP_VEC (TV)
    ) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .branch_taken_in        (branch_taken),
        .exec_valid_in          (exec_valid),
        .opcode_in              (opcode),
        .exec_pc_in             (exec_pc),
        .rs1_in                 (rs1),
        .imm_in                 (imm),
        .stall_in               (stall),
        .imem                   (imem.master),
        .instr_valid_out        (instr_valid),
        .instr_out              (instr),
        .instr_pc_out           (instr_pc),
        .flush_out              (flush),
        .misaligned_exc_out     (exc),
        .misaligned_addr_out    (exc_addr)
    );

    int errors = 0;
    int checks = 0;

    // Model: warm = first cycle after reset; busy = request in flight; killed = its
    // response must be dropped; have = instruction presented to decode.
    bit          warm, busy, killed, have, m_flush, m_exc;
    logic [31:0] next_addr, pend_pc, held_pc, held_instr, m_exc_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = !warm && !busy && !have;
        chk("req_valid", 32'(imem.imem_req_valid_out), 32'(exp_req));
        chk("req_addr", imem.imem_req_addr_out, exp_req ? next_addr : 32'h0);
        chk("instr_valid", 32'(instr_valid), 32'(have));
        if (have) begin
            chk("instr", instr, held_instr);
            chk("instr_pc", instr_pc, held_pc);
        end
        chk("flush", 32'(flush), 32'(m_flush));
        chk("exc", 32'(exc), 32'(m_exc));
        if (m_exc) chk("exc_addr", exc_addr, m_exc_addr);
    endtask

    task automatic set_idle();
        exec_valid = 1'b0; branch_taken = 1'b0; opcode = 5'b01100;
        exec_pc = 32'h0; rs1 = 32'h0; imm = 32'h0; stall = 1'b0;
        imem.imem_req_ready_in = 1'b0;
        imem.imem_rsp_valid_in = 1'b0;
        imem.imem_rsp_data_in  = 32'h0;
    endtask

    // Advance one clock: update the model from the driven inputs, then check at negedge.
    task automatic cyc();
        bit          redir, mis, hs;
        logic [31:0] tgt, newpc;
        redir = exec_valid && branch_taken &&
                (opcode == OPC_JAL || opcode == OPC_JALR || opcode == OPC_BRANCH);
        tgt   = (opcode == OPC_JALR) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (exec_pc + imm);
        mis   = (tgt & 32'd3) != 32'd0;
        newpc = mis ? TV : tgt;
        hs    = !warm && !busy && !have && imem.imem_req_ready_in;
        m_flush    = redir;
        m_exc      = redir && mis;
        m_exc_addr = tgt;
        if (warm) begin
            warm      = 1'b0;
            next_addr = redir ? newpc : RPC;
        end else if (hs) begin
            busy      = 1'b1;
            pend_pc   = next_addr;
            killed    = redir;
            next_addr = redir ? newpc : next_addr + 32'd4;
        end else if (busy) begin
            if (redir) next_addr = newpc;
            if (imem.imem_rsp_valid_in) begin
                busy = 1'b0;
                if (!killed && !redir) begin
                    have       = 1'b1;
                    held_pc    = pend_pc;
                    held_instr = imem.imem_rsp_data_in;
                end
            end else if (redir) begin
                killed = 1'b1;
            end
        end else if (have) begin
            if (redir) begin
                have      = 1'b0;
                next_addr = newpc;
            end else if (!stall) begin
                have = 1'b0;
            end
        end else if (redir) begin
            next_addr = newpc;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem.imem_req_valid_out), 32'h0);
        chk("rst_req_addr", imem.imem_req_addr_out, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_exc", 32'(exc), 32'h0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        warm = 1'b1; busy = 1'b0; killed = 1'b0; have = 1'b0;
        m_flush = 1'b0; m_exc = 1'b0; next_addr = RPC;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    task automatic jump(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] im);
        exec_valid = 1'b1; branch_taken = 1'b1; opcode = op;
        exec_pc = pc; rs1 = r1; imm = im;
    endtask

    task automatic no_jump();
        exec_valid = 1'b0; branch_taken = 1'b0; opcode = 5'b01100;
    endtask

    initial begin
        set_idle();
        do_reset();
        cyc();
        chk("seq_addr0", imem.imem_req_addr_out, 32'h100);
        // Sequential fetch with one-cycle ready and response.
        for (int k = 0; k < 2; k++) begin
            imem.imem_req_ready_in = 1'b1; cyc();
            imem.imem_req_ready_in = 1'b0;
            imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'hA000_0000 + k; cyc();
            imem.imem_rsp_valid_in = 1'b0;
            chk("seq_pc", instr_pc, 32'h100 + 32'(k) * 4);
            cyc();
        end
        chk("seq_addr2", imem.imem_req_addr_out, 32'h108);
        // Branch while waiting, with the response arriving the same cycle.
        imem.imem_req_ready_in = 1'b1; cyc();
        imem.imem_req_ready_in = 1'b0;
        jump(OPC_BRANCH, 32'h200, 32'h0, 32'h40);
        imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'hDEAD_0001; cyc();
        imem.imem_rsp_valid_in = 1'b0; no_jump();
        chk("br_flush", 32'(flush), 32'h1);
        chk("br_drop", 32'(instr_valid), 32'h0);
        chk("br_addr", imem.imem_req_addr_out, 32'h240);
        cyc();
        // Taken decision without exec_valid must be ignored.
        branch_taken = 1'b1; opcode = OPC_JAL; imm = 32'h80; cyc();
        chk("novalid_flush", 32'(flush), 32'h0);
        // JALR aligned then misaligned target.
        jump(OPC_JALR, 32'h0, 32'h1001, 32'h3); cyc();
        chk("jalr_addr", imem.imem_req_addr_out, 32'h1004);
        jump(OPC_JALR, 32'h0, 32'h1003, 32'h4); cyc();
        no_jump();
        chk("mis_exc", 32'(exc), 32'h1);
        chk("mis_addr", exc_addr, 32'h1006);
        chk("mis_trap", imem.imem_req_addr_out, TV);
        cyc();
        // Stall in HOLD for three cycles.
        imem.imem_req_ready_in = 1'b1; cyc();
        imem.imem_req_ready_in = 1'b0;
        imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'h1234_5678; cyc();
        imem.imem_rsp_valid_in = 1'b0;
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_req", 32'(imem.imem_req_valid_out), 32'h0);
            chk("stall_instr", instr, 32'h1234_5678);
        end
        stall = 1'b0; cyc();
        chk("stall_next", imem.imem_req_addr_out, 32'h8);
        // Address wrap at the top of memory.
        jump(OPC_JAL, 32'h0, 32'h0, 32'hFFFF_FFFC); cyc();
        no_jump();
        imem.imem_req_ready_in = 1'b1; cyc();
        imem.imem_req_ready_in = 1'b0;
        imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'h5555_AAAA; cyc();
        imem.imem_rsp_valid_in = 1'b0;
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr", imem.imem_req_addr_out, 32'h0);
        // Redirect on the handshake cycle: the following response is stale.
        imem.imem_req_ready_in = 1'b1;
        jump(OPC_JAL, 32'h300, 32'h0, 32'h10); cyc();
        imem.imem_req_ready_in = 1'b0; no_jump();
        imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'hBAD0_BAD0; cyc();
        imem.imem_rsp_valid_in = 1'b0;
        chk("stale_drop", 32'(instr_valid), 32'h0);
        chk("stale_addr", imem.imem_req_addr_out, 32'h310);
        // Redirect during HOLD together with a stall.
        imem.imem_req_ready_in = 1'b1; cyc();
        imem.imem_req_ready_in = 1'b0;
        imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'h0F0F_0F0F; cyc();
        imem.imem_rsp_valid_in = 1'b0;
        stall = 1'b1; jump(OPC_BRANCH, 32'h400, 32'h0, 32'h20); cyc();
        stall = 1'b0; no_jump();
        chk("hold_drop", 32'(instr_valid), 32'h0);
        chk("hold_addr", imem.imem_req_addr_out, 32'h420);
        // Reset while a request is outstanding; the late response must be ignored.
        imem.imem_req_ready_in = 1'b1; cyc();
        imem.imem_req_ready_in = 1'b0;
        do_reset();
        imem.imem_rsp_valid_in = 1'b1; imem.imem_rsp_data_in = 32'hFFFF_0000; cyc();
        imem.imem_rsp_valid_in = 1'b0;
        chk("rst_late_addr", imem.imem_req_addr_out, RPC);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            imem.imem_req_ready_in = ($urandom % 2) == 0;
            imem.imem_rsp_valid_in = busy ? (($urandom % 2) == 0) : (($urandom % 10) == 0);
            imem.imem_rsp_data_in  = $urandom;
            stall        = ($urandom % 3) == 0;
            exec_valid   = ($urandom % 4) != 0;
            branch_taken = ($urandom % 3) == 0;
            case ($urandom % 4)
                0: opcode = OPC_JAL;
                1: opcode = OPC_JALR;
                2: opcode = OPC_BRANCH;
                default: opcode = 5'b01100;
            endcase
            exec_pc = $urandom & 32'hFFFF_FFFC;
            rs1     = $urandom;
            if (($urandom % 6) == 0) imm = 32'($urandom % 8);
            else imm = 32'(($urandom % 64) * 4) - 32'd128;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msrv32_fetch_redirect.md
MSRV32_FETCH_REDIRECT -- requirements
Module: msrv32_fetch_redirect

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TRAP_VEC, 32'h0000_0004, fetch address after a misaligned-target exception.
REQ-003 ms_riscv32_mp_clk_in  in  1  single clock; all state on rising edge.
REQ-004 ms_riscv32_mp_rst_n_in  in  1  reset, asynchronous, active-low.
REQ-005 branch_taken_in  in  1  taken decision from the branch unit for the instruction in execute.
REQ-006 exec_valid_in  in  1  execute stage holds a valid instruction.
REQ-007 opcode_in  in  5  opcode[6:2] of the execute instruction.
REQ-008 exec_pc_in  in  32  PC of the execute instruction.
REQ-009 rs1_in  in  32  rs1 operand; imm_in  in  32  sign-extended immediate.
REQ-010 stall_in  in  1  decode not accepting instr_out.
REQ-011 imem_req_valid_out  out  1; imem_req_addr_out  out  32; imem_req_ready_in  in  1: fetch request handshake.
REQ-012 imem_rsp_valid_in  in  1; imem_rsp_data_in  in  32: fetch response, one per accepted request, in order.
REQ-013 instr_valid_out  out  1; instr_out  out  32; instr_pc_out  out  32: fetched instruction to decode.
REQ-014 flush_out  out  1  one-cycle pulse: younger in-flight instructions must be killed.
REQ-015 misaligned_exc_out  out  1; misaligned_addr_out  out  32: misaligned target exception.

Function
REQ-016 Redirect SHALL occur when exec_valid_in=1, branch_taken_in=1 and opcode_in is JAL (11011), JALR (11001) or BRANCH (11000); otherwise branch_taken_in is ignored.
REQ-017 Target: JAL/BRANCH = exec_pc_in+imm_in; JALR = (rs1_in+imm_in) with bit0 cleared; 32-bit modulo arithmetic, carry discarded.
REQ-018 Target[1:0]!=0 SHALL assert misaligned_exc_out and misaligned_addr_out=target next cycle for one cycle, and redirect to TRAP_VEC instead of target.
REQ-019 FSM states: RESET_S, REQ_S, WAIT_S, HOLD_S; at most one outstanding request.
REQ-020 RESET_S: one cycle after reset release, then REQ_S with fetch_pc=RESET_PC.
REQ-021 REQ_S: imem_req_valid_out=1, addr=fetch_pc; on ready_in=1 go WAIT_S, fetch_pc+=4 (0xFFFF_FFFC wraps to 0).
REQ-022 WAIT_S: on rsp_valid_in capture data/PC into output registers, go HOLD_S; instr_valid_out=1 the following cycle.
REQ-023 HOLD_S: hold instr_valid_out/instr_out/instr_pc_out stable while stall_in=1; when stall_in=0 the instruction is consumed that cycle, go REQ_S.
REQ-024 Redirect in REQ_S without handshake: fetch_pc<=target, stay REQ_S (address changes while unaccepted).
REQ-025 Redirect coincident with handshake: request counts as accepted, marked stale; its response SHALL be discarded, then REQ_S with fetch_pc=target.
REQ-026 Redirect in WAIT_S (including same cycle as rsp_valid_in): pending response discarded, then REQ_S at target.
REQ-027 Redirect in HOLD_S: held instruction dropped (instr_valid_out=0 next cycle), go REQ_S at target.
REQ-028 flush_out SHALL be registered, high exactly the cycle after the redirect is sampled.
REQ-029 rsp_valid_in with no outstanding request, or in RESET_S, SHALL be ignored.
REQ-030 Redirect on the same cycle as a stall: redirect wins.

Reset
REQ-031 Asserted reset SHALL immediately force RESET_S, fetch_pc=RESET_PC, stale flag=0, all outputs 0 (addresses 0).
REQ-032 Reset mid-request SHALL abandon the outstanding request; later responses are ignored under REQ-029.

Structure
REQ-033 Opcode constants JAL/JALR/BRANCH and FSM state encodings SHALL live in the shared msrv32 package used by the branch unit.
REQ-034 Target computation and misalignment check SHALL be one combinational sub-module, msrv32_target_gen.

Verification
REQ-035 RESET_PC=0x100, ready/rsp after 1 cycle -> requests 0x100, 0x104, 0x108 in order, instr_pc_out matching.
REQ-036 In WAIT_S, BRANCH exec_pc=0x200 imm=0x40 taken -> flush_out pulse, old response dropped, next request 0x240.
REQ-037 JALR rs1=0x1001 imm=0x3 -> request 0x1004; JALR rs1=0x1003 imm=0x4 -> misaligned_exc_out, addr 0x1006, next request TRAP_VEC.
REQ-038 stall_in high 3 cycles in HOLD_S -> outputs stable, imem_req_valid_out=0 throughout, next request after release.
REQ-039 fetch_pc=0xFFFF_FFFC handshake -> next request 0x0000_0000.
REQ-040 Redirect on handshake cycle, response next cycle -> response discarded, instr_valid_out stays 0, next request = target.
